parity_frame_tx: RTL

Serial frame transmitter directly downstream of the 16-bit parity generator. Accepts a data word plus its generated parity bit through a valid/ready handshake. Emits a UART-style frame on a single line: start bit, data LSB-first, parity bit, stop bit. Also flags words whose supplied parity disagrees with a local recomputation.

---
 rtl/parity_pkg.sv | 25 ++
 rtl/parity_frame_tx_bit_timer.sv | 42 ++++
 rtl/parity_frame_tx.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/parity_pkg.sv
// -----------------------------------------------------------------------------
// parity_pkg
// Shared definitions for the parity frame transmitter slice: FSM state
// encoding, the default data width and the number of non-data bits in a frame
// (start + parity + stop).
// -----------------------------------------------------------------------------
package parity_pkg;

  localparam int W_DEFAULT   = 16;
  localparam int FRAME_EXTRA = 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Total frame length in clock cycles for a given word width and bit period.
  function automatic int frame_cycles(input int w, input int cpb);
    return (w + FRAME_EXTRA) * cpb;
  endfunction

endpackage

// File: rtl/parity_frame_tx_bit_timer.sv
// -----------------------------------------------------------------------------
// bit_timer
// Bit-period timer for the frame transmitter. Counts 0..CLKS_PER_BIT-1 while
// enabled and pulses bit_tick on the terminal count. Held at zero while
// disabled so every frame starts on a fresh bit period.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous, active-high reset
//   en       count enable (frame in progress)
//   bit_tick high on the last cycle of each bit period while enabled
// -----------------------------------------------------------------------------
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bit_tick
);

  // A 1-bit counter is kept even when CLKS_PER_BIT is 1; it simply stays at 0.
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt == TERM) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_tick = en && (cnt == TERM);

endmodule

// File: rtl/parity_frame_tx.sv
// -----------------------------------------------------------------------------
// parity_frame_tx
// Serial frame transmitter fed by the parity generator. Accepts a data word and
// its even-parity bit, then sends start(0), data LSB-first, parity, stop(1) on
// tx_out, each bit held CLKS_PER_BIT cycles. Flags words whose supplied parity
// disagrees with a local XOR of the data.
//
// Build option: define PARITY_ODD_EN to send the inverted (odd) parity bit on
// the line. The mismatch check always compares against even parity.
//
// Handshake: a word is taken on a rising edge where in_valid && in_ready.
// in_ready is high only in IDLE (and never during reset); in_valid while busy
// is ignored, so upstream holds its word until it sees in_ready.
//
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   in_valid      upstream word available
//   in_ready      transmitter idle and able to take a word
//   in_data       data word (W bits)
//   in_parity     even-parity bit for in_data
//   tx_out        registered serial line, idles high
//   busy          frame in progress
//   done          one-cycle pulse on the final cycle of the stop bit
//   par_mismatch  supplied parity disagreed with XOR of the data (held)
//   state_dbg     current FSM state encoding
// -----------------------------------------------------------------------------
module parity_frame_tx
  import parity_pkg::*;
#(
  parameter int W            = W_DEFAULT,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_parity,
  output logic         tx_out,
  output logic         busy,
  output logic         done,
  output logic         par_mismatch,
  output logic [2:0]   state_dbg
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

  state_t        state;
  logic [W-1:0]  shift_reg;
  logic [IW-1:0] data_idx;
  logic          par_q;
  logic          line_parity;
  logic          bit_tick;
  logic          accept;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .en      (busy),
    .bit_tick(bit_tick)
  );

`ifdef PARITY_ODD_EN
  assign line_parity = ~par_q;
`else
  assign line_parity = par_q;
`endif

  assign busy      = (state != S_IDLE);
  assign in_ready  = (state == S_IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign done      = (state == S_STOP) && bit_tick;
  assign state_dbg = state;

  // tx_out is loaded with the value of the bit that starts on the next cycle,
  // so the line changes exactly on bit boundaries straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      tx_out       <= 1'b1;
      shift_reg    <= '0;
      data_idx     <= '0;
      par_q        <= 1'b0;
      par_mismatch <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          tx_out <= 1'b1;
          if (accept) begin
            shift_reg    <= in_data;
            par_q        <= in_parity;
            par_mismatch <= (in_parity != ^in_data);
            data_idx     <= '0;
            tx_out       <= 1'b0;
            state        <= S_START;
          end
        end
        S_START: begin
          if (bit_tick) begin
            tx_out <= shift_reg[0];
            state  <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_tick) begin
            if (data_idx == LAST_IDX) begin
              tx_out <= line_parity;
              state  <= S_PARITY;
            end else begin
              // Next bit on the line is the one that becomes bit 0 after the shift.
              tx_out    <= shift_reg[1];
              shift_reg <= shift_reg >> 1;
              data_idx  <= data_idx + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (bit_tick) begin
            tx_out <= 1'b1;
            state  <= S_STOP;
          end
        end
        S_STOP: begin
          if (bit_tick) begin
            tx_out <= 1'b1;
            state  <= S_IDLE;
          end
        end
        default: begin
          tx_out <= 1'b1;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
